// File: rtl/adc_entropy_pkg.sv
// ---------------------------------------------------------------------------
// adc_entropy_pkg
// Shared definitions for the ADC entropy capture block.
//   MODE_*   : 2-bit runtime mode encodings (RAW, XOR, VN, COUNT)
//   STAT_W   : width of the saturating statistics counters
//   sat_inc  : saturating increment for the statistics counters
// ---------------------------------------------------------------------------
package adc_entropy_pkg;

  localparam logic [1:0] MODE_RAW   = 2'b00;
  localparam logic [1:0] MODE_XOR   = 2'b01;
  localparam logic [1:0] MODE_VN    = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  localparam int STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] i_v);
    return (&i_v) ? i_v : i_v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// ---------------------------------------------------------------------------
// rng_sync_fifo
// Single-clock show-ahead FIFO. The head word is visible on o_data whenever
// o_empty is low; o_data reads 0 while empty.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_push, i_push_data : write request and data
//   i_pop               : remove head word (ignored when empty)
//   o_data              : head word
//   o_empty, o_full     : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the word is dropped (the caller accounts for the drop).
// ---------------------------------------------------------------------------
module rng_sync_fifo #(
  parameter int P_WIDTH = 32,
  parameter int P_DEPTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [P_WIDTH-1:0] i_push_data,
  input  logic               i_pop,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_empty,
  output logic               o_full
);

  localparam int AW = $clog2(P_DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [P_WIDTH-1:0] r_mem [P_DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // When full, the slot being popped this cycle is the one the push reuses.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/adc_entropy_capture.sv
// ---------------------------------------------------------------------------
// adc_entropy_capture
// Turns N synchronous ADC channels into packed words for the HPS, via a
// show-ahead FIFO on a valid/ready stream.
// Ports:
//   clk, reset_n   : sample clock, synchronous active-low reset
//   enable         : take one sample per cycle while high
//   mode           : 00 RAW, 01 XOR, 10 VN (von Neumann), 11 COUNT
//   clr_stats      : one-cycle pulse clearing or_cnt and ovf_cnt
//   ad_d, ad_or    : channel samples (channel c at [c*P_DATA_W +: P_DATA_W])
//                    and per-channel over-range flags
//   out_data/out_valid/out_ready : output stream (FIFO head)
//   or_cnt         : over-range samples discarded (XOR/VN), saturating
//   ovf_cnt        : words dropped on a full FIFO, saturating
// Stream handshake: out_valid means out_data holds a word; a word transfers
// on every clock edge where out_valid && out_ready, and out_data does not
// change while out_valid && !out_ready.
// Pipeline: stage 1 registers the inputs; stage 2 (word builder) works on
// the registered sample and writes a finished word into the FIFO on the
// next edge, so a word is visible two edges after its last sample.
// ---------------------------------------------------------------------------
module adc_entropy_capture
  import adc_entropy_pkg::*;
#(
  parameter int P_CHANNELS   = 2,
  parameter int P_DATA_W     = 14,
  parameter int P_OUT_W      = 32,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic                           clr_stats,
  input  logic [P_CHANNELS*P_DATA_W-1:0] ad_d,
  input  logic [P_CHANNELS-1:0]          ad_or,
  output logic [P_OUT_W-1:0]             out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [STAT_W-1:0]              or_cnt,
  output logic [STAT_W-1:0]              ovf_cnt
);

  localparam int IDX_W = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;
  localparam int BC_W  = $clog2(P_OUT_W) + 1;

  // Stage 1: sample register
  logic                           r_en;
  logic [1:0]                     r_mode;
  logic [P_CHANNELS*P_DATA_W-1:0] r_ad_d;
  logic [P_CHANNELS-1:0]          r_ad_or;

  // Stage 2: word builder state
  logic [1:0]         r_prev_mode;
  logic [P_OUT_W-1:0] r_acc;
  logic [BC_W-1:0]    r_bitcnt;
  logic               r_half;
  logic               r_first;
  logic [IDX_W-1:0]   r_idx;
  logic [P_OUT_W-1:0] r_count;

  logic [STAT_W-1:0]  r_or_cnt;
  logic [STAT_W-1:0]  r_ovf_cnt;

  // Builder combinational view
  logic               w_clear;
  logic [P_OUT_W-1:0] w_acc_b,    w_acc_n;
  logic [BC_W-1:0]    w_bitcnt_b, w_bitcnt_n;
  logic               w_half_b,   w_half_n;
  logic               w_first_b,  w_first_n;
  logic [IDX_W-1:0]   w_idx_b,    w_idx_n;
  logic [P_OUT_W-1:0] w_count_b,  w_count_n;
  logic [P_DATA_W-1:0] w_raw_sample;
  logic               w_xor_bit;
  logic               w_take;
  logic               w_take_bit;
  logic               w_push;
  logic [P_OUT_W-1:0] w_push_data;
  logic               w_or_inc;

  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_pop;
  logic               w_ovf_inc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_en    <= 1'b0;
      r_mode  <= MODE_RAW;
      r_ad_d  <= '0;
      r_ad_or <= '0;
    end else begin
      r_en    <= enable;
      r_mode  <= mode;
      r_ad_d  <= ad_d;
      r_ad_or <= ad_or;
    end
  end

  always_comb begin
    // A mode switch or an idle cycle restarts all partial state; the new
    // sample (if any) is then processed from a clean slate.
    w_clear    = !r_en || (r_mode != r_prev_mode);
    w_acc_b    = w_clear ? '0   : r_acc;
    w_bitcnt_b = w_clear ? '0   : r_bitcnt;
    w_half_b   = w_clear ? 1'b0 : r_half;
    w_first_b  = w_clear ? 1'b0 : r_first;
    w_idx_b    = w_clear ? '0   : r_idx;
    w_count_b  = w_clear ? '0   : r_count;

    w_acc_n    = w_acc_b;
    w_bitcnt_n = w_bitcnt_b;
    w_half_n   = w_half_b;
    w_first_n  = w_first_b;
    w_idx_n    = w_idx_b;
    w_count_n  = w_count_b;

    w_raw_sample = '0;
    w_xor_bit    = 1'b0;
    for (int c = 0; c < P_CHANNELS; c++) begin
      if (w_idx_b == IDX_W'(c)) w_raw_sample = r_ad_d[c*P_DATA_W +: P_DATA_W];
      w_xor_bit = w_xor_bit ^ r_ad_d[c*P_DATA_W];
    end

    w_take      = 1'b0;
    w_take_bit  = 1'b0;
    w_push      = 1'b0;
    w_push_data = '0;
    w_or_inc    = 1'b0;

    if (r_en) begin
      case (r_mode)
        MODE_RAW: begin
          w_push      = 1'b1;
          w_push_data = P_OUT_W'(w_raw_sample);
          w_idx_n     = (int'(w_idx_b) == P_CHANNELS - 1) ? '0 : w_idx_b + IDX_W'(1);
        end
        MODE_XOR: begin
          if (|r_ad_or) begin
            w_or_inc = 1'b1;
          end else begin
            w_take     = 1'b1;
            w_take_bit = w_xor_bit;
          end
        end
        MODE_VN: begin
          if (|r_ad_or) begin
            w_or_inc = 1'b1;
          end else if (!w_half_b) begin
            w_half_n  = 1'b1;
            w_first_n = w_xor_bit;
          end else begin
            // 01 -> 0, 10 -> 1: the emitted bit is the pair's first bit.
            w_half_n   = 1'b0;
            w_take     = (w_first_b != w_xor_bit);
            w_take_bit = w_first_b;
          end
        end
        default: begin
          w_push      = 1'b1;
          w_push_data = w_count_b;
          w_count_n   = w_count_b + P_OUT_W'(1);
        end
      endcase

      // Shift in at the LSB so the first bit of a word ends up in the MSB.
      if (w_take) begin
        w_acc_n = (w_acc_b << 1) | P_OUT_W'(w_take_bit);
        if (w_bitcnt_b == BC_W'(P_OUT_W - 1)) begin
          w_push      = 1'b1;
          w_push_data = w_acc_n;
          w_bitcnt_n  = '0;
        end else begin
          w_bitcnt_n = w_bitcnt_b + BC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev_mode <= MODE_RAW;
      r_acc       <= '0;
      r_bitcnt    <= '0;
      r_half      <= 1'b0;
      r_first     <= 1'b0;
      r_idx       <= '0;
      r_count     <= '0;
    end else begin
      r_prev_mode <= r_mode;
      r_acc       <= w_acc_n;
      r_bitcnt    <= w_bitcnt_n;
      r_half      <= w_half_n;
      r_first     <= w_first_n;
      r_idx       <= w_idx_n;
      r_count     <= w_count_n;
    end
  end

  rng_sync_fifo #(
    .P_WIDTH (P_OUT_W),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_data      (out_data),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  assign out_valid = !w_fifo_empty;
  assign w_pop     = out_valid && out_ready;
  assign w_ovf_inc = w_push && w_fifo_full && !w_pop;

  // clr_stats wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_or_cnt  <= '0;
      r_ovf_cnt <= '0;
    end else if (clr_stats) begin
      r_or_cnt  <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_or_inc)  r_or_cnt  <= sat_inc(r_or_cnt);
      if (w_ovf_inc) r_ovf_cnt <= sat_inc(r_ovf_cnt);
    end
  end

  assign or_cnt  = r_or_cnt;
  assign ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_adc_entropy_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_entropy_capture
// Directed scenarios with literal expectations, then a randomized run.
// A behavioural model (bit queues, word queue standing in for the FIFO)
// predicts out_valid/out_data/or_cnt/ovf_cnt, checked every falling edge.
// ---------------------------------------------------------------------------
module tb_adc_entropy_capture;

  localparam int NCH   = 2;
  localparam int DW    = 14;
  localparam int OW    = 32;
  localparam int DEPTH = 16;
  localparam int ADW   = NCH * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            enable;
  logic [1:0]      mode;
  logic            clr_stats;
  logic [ADW-1:0]  ad_d;
  logic [NCH-1:0]  ad_or;
  logic [OW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     or_cnt;
  logic [15:0]     ovf_cnt;

  adc_entropy_capture #(
    .P_CHANNELS   (NCH),
    .P_DATA_W     (DW),
    .P_OUT_W      (OW),
    .P_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .mode      (mode),
    .clr_stats (clr_stats),
    .ad_d      (ad_d),
    .ad_or     (ad_or),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .or_cnt    (or_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [OW-1:0]  exp_q[$];   // words the FIFO should hold, head first
  logic [OW-1:0]  got_q[$];   // words the DUT handed over (for literal checks)
  int             m_or, m_ovf;
  bit             s1_en;
  logic [1:0]     s1_mode, m_prev_mode;
  logic [ADW-1:0] s1_d;
  logic [NCH-1:0] s1_or;
  bit             m_bits[$];
  bit             vn_have, vn_b;
  int             m_idx;
  logic [OW-1:0]  m_cnt;

  function automatic bit lsb_xor(input logic [ADW-1:0] d);
    bit r;
    r = 1'b0;
    for (int c = 0; c < NCH; c++) r = r ^ d[c*DW];
    return r;
  endfunction

  always @(posedge clk) begin : model_p
    bit push, emit, ebit, b, or_inc, ovf_inc;
    logic [OW-1:0]  w;
    logic [ADW-1:0] sh;
    push = 0; emit = 0; ebit = 0; or_inc = 0; ovf_inc = 0; w = '0;
    if (!reset_n) begin
      exp_q.delete(); m_bits.delete();
      m_or = 0; m_ovf = 0;
      s1_en = 0; s1_mode = 2'd0; s1_d = '0; s1_or = '0; m_prev_mode = 2'd0;
      vn_have = 0; vn_b = 0; m_idx = 0; m_cnt = '0;
    end else begin
      if (!s1_en || s1_mode != m_prev_mode) begin
        m_bits.delete(); vn_have = 0; vn_b = 0; m_idx = 0; m_cnt = '0;
      end
      m_prev_mode = s1_mode;
      if (s1_en) begin
        case (s1_mode)
          2'd0: begin
            sh   = s1_d >> (m_idx * DW);
            w    = OW'(sh[DW-1:0]);
            push = 1;
            m_idx = (m_idx + 1) % NCH;
          end
          2'd3: begin
            w = m_cnt; push = 1; m_cnt = m_cnt + 1;
          end
          default: begin
            if (s1_or != '0) begin
              or_inc = 1;
            end else begin
              b = lsb_xor(s1_d);
              if (s1_mode == 2'd1) begin
                emit = 1; ebit = b;
              end else if (!vn_have) begin
                vn_have = 1; vn_b = b;
              end else begin
                vn_have = 0;
                if (vn_b != b) begin emit = 1; ebit = vn_b; end
              end
            end
          end
        endcase
        if (emit) begin
          m_bits.push_back(ebit);
          if (m_bits.size() == OW) begin
            for (int i = 0; i < OW; i++) w[OW-1-i] = m_bits[i];
            push = 1;
            m_bits.delete();
          end
        end
      end
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else ovf_inc = 1;
      end
      if (clr_stats) begin
        m_or = 0; m_ovf = 0;
      end else begin
        if (or_inc  && m_or  < 65535) m_or++;
        if (ovf_inc && m_ovf < 65535) m_ovf++;
      end
      s1_en = enable; s1_mode = mode; s1_d = ad_d; s1_or = ad_or;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q[0]));
      check("or_cnt", 64'(or_cnt), 64'(m_or));
      check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit en, input logic [1:0] md, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1, input logic [NCH-1:0] orv);
    enable = en; mode = md; ad_d = {d1, d0}; ad_or = orv;
  endtask

  // Random upper bits, chosen LSB.
  function automatic logic [DW-1:0] rnd_lsb(input bit lsb);
    logic [DW-1:0] r;
    r = DW'($urandom());
    r[0] = lsb;
    return r;
  endfunction

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  bit vn_pat[8] = '{0, 1, 1, 0, 0, 0, 1, 1};

  initial begin
    reset_n = 0; enable = 0; mode = 2'd0; clr_stats = 0;
    ad_d = '0; ad_or = '0; out_ready = 1;
    step();
    chk_en = 1'b1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data",  64'(out_data),  64'(0));
    check("rst_or",    64'(or_cnt),    64'(0));
    check("rst_ovf",   64'(ovf_cnt),   64'(0));
    step();
    reset_n = 1;

    // COUNT from reset: valid two edges after enable, then 0,1,2,... gapless
    got_q.delete();
    set_in(1, 2'd3, '0, '0, '0);
    step();
    check("cnt_lat1_valid", 64'(out_valid), 64'(0));
    step();
    check("cnt_lat2_valid", 64'(out_valid), 64'(1));
    check("cnt_first",      64'(out_data),  64'(0));
    repeat (6) step();
    idle(3);
    check("cnt_words", 64'(got_q.size()), 64'(8));
    for (int i = 0; i < got_q.size(); i++) check("cnt_seq", 64'(got_q[i]), 64'(i));

    // XOR: ch0 LSB 1,0,1,0..., ch1 LSB 0 -> 0xAAAAAAAA
    got_q.delete();
    for (int i = 0; i < 32; i++) begin
      set_in(1, 2'd1, rnd_lsb(i % 2 == 0), rnd_lsb(0), '0);
      step();
    end
    check("xor_pre_valid", 64'(out_valid), 64'(0));
    idle(1);
    check("xor_valid", 64'(out_valid), 64'(1));
    check("xor_word",  64'(out_data),  64'(32'hAAAA_AAAA));
    idle(3);
    check("xor_words", 64'(got_q.size()), 64'(1));

    // VN: XOR stream 0,1,1,0,0,0,1,1 repeated -> 0x55555555 after 128 samples
    got_q.delete();
    for (int i = 0; i < 128; i++) begin
      set_in(1, 2'd2, rnd_lsb(vn_pat[i % 8]), rnd_lsb(0), '0);
      step();
    end
    idle(4);
    check("vn_words", 64'(got_q.size()), 64'(1));
    if (got_q.size() != 0) check("vn_word", 64'(got_q[0]), 64'(32'h5555_5555));

    // Over-range: 10 discarded samples push word completion out by 10
    clr_stats = 1; step(); clr_stats = 0;
    got_q.delete();
    for (int i = 0; i < 42; i++) begin
      set_in(1, 2'd1, rnd_lsb(1), rnd_lsb(0), (i >= 5 && i < 15) ? 2'b10 : 2'b00);
      step();
    end
    check("or_pre_valid", 64'(out_valid), 64'(0));
    idle(1);
    check("or_valid", 64'(out_valid), 64'(1));
    check("or_word",  64'(out_data),  64'(32'hFFFF_FFFF));
    check("or_cnt_10", 64'(or_cnt),   64'(10));
    idle(3);
    check("or_words", 64'(got_q.size()), 64'(1));

    // Backpressure: 20 COUNT words into a 16-deep FIFO
    got_q.delete();
    out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      set_in(1, 2'd3, '0, '0, '0);
      step();
    end
    idle(2);
    check("bp_ovf",   64'(ovf_cnt),   64'(4));
    check("bp_valid", 64'(out_valid), 64'(1));
    out_ready = 1;
    idle(20);
    check("bp_words", 64'(got_q.size()), 64'(16));
    for (int i = 0; i < got_q.size(); i++) check("bp_seq", 64'(got_q[i]), 64'(i));
    check("bp_drained", 64'(out_valid), 64'(0));

    // Reset mid-XOR-word with a non-empty FIFO and non-zero counters
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin set_in(1, 2'd3, '0, '0, '0); step(); end
    for (int i = 0; i < 10; i++) begin
      set_in(1, 2'd1, rnd_lsb(1), rnd_lsb(0), (i == 4) ? 2'b01 : 2'b00);
      step();
    end
    reset_n = 0;
    step();
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_or",    64'(or_cnt),    64'(0));
    check("mid_rst_ovf",   64'(ovf_cnt),   64'(0));
    reset_n = 1;
    out_ready = 1;
    got_q.delete();
    for (int i = 0; i < 32; i++) begin
      set_in(1, 2'd1, rnd_lsb(i % 2 == 0), rnd_lsb(0), '0);
      step();
    end
    idle(4);
    check("post_rst_words", 64'(got_q.size()), 64'(1));
    if (got_q.size() != 0) check("post_rst_word", 64'(got_q[0]), 64'(32'hAAAA_AAAA));

    // XOR -> RAW mid-word: no partial word, RAW starts at channel 0
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 2'd1, rnd_lsb(i % 2 == 0), rnd_lsb(0), '0);
      step();
    end
    set_in(1, 2'd0, 14'h1234, 14'h0567, 2'b11); step();
    set_in(1, 2'd0, 14'h2abc, 14'h0def, 2'b00); step();
    idle(4);
    check("raw_words", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      check("raw_ch0", 64'(got_q[0]), 64'(14'h1234));
      check("raw_ch1", 64'(got_q[1]), 64'(14'h0def));
    end

    // Randomized run, checked every cycle against the model
    enable = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      ad_d      = ADW'($urandom());
      ad_or     = ($urandom_range(0, 7) == 0) ? NCH'($urandom_range(1, 3)) : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 63) == 0);
      reset_n   = ($urandom_range(0, 999) != 0);
      step();
    end
    reset_n = 1; clr_stats = 0; out_ready = 1;
    idle(DEPTH + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_entropy_capture.md
# adc_entropy_capture

Parametrised successor to the per-ADC interface controller. It takes N synchronous ADC channels and turns them into packed output words for the HPS over a valid/ready stream with a built-in FIFO. Four runtime modes are supported: raw samples, XOR entropy, von Neumann–debiased entropy and a test counter. It sits between the AD9254 capture path and the HPS-facing streaming/DMA logic in the RNG design.

## Interface
Parameters:
- P_CHANNELS, default 2: number of ADC channels, minimum 1.
- P_DATA_W, default 14: bits per ADC sample.
- P_OUT_W, default 32: output word width; must be ≥ P_DATA_W.
- P_FIFO_DEPTH, default 16: FIFO depth in words; must be a power of 2, minimum 2.

Ports (all synchronous to clk):
- clk, in, 1: ADC sample clock; the only clock.
- reset_n, in, 1: synchronous, active-low reset.
- enable, in, 1: when high, a sample is taken every cycle.
- mode, in, 2: 00 RAW, 01 XOR, 10 VN, 11 COUNT.
- clr_stats, in, 1: one-cycle pulse that clears both statistics counters.
- ad_d, in, P_CHANNELS*P_DATA_W: channel c occupies bits [c*P_DATA_W +: P_DATA_W].
- ad_or, in, P_CHANNELS: per-channel over-range flag.
- out_data, out, P_OUT_W: FIFO head word.
- out_valid, out, 1: FIFO not empty.
- out_ready, in, 1: consumer accepts the head word.
- or_cnt, out, 16: discarded over-range samples, saturating.
- ovf_cnt, out, 16: words dropped because the FIFO was full, saturating.

## Operation
- Stage 1 registers enable, mode, ad_d and ad_or every cycle (the sample register).
- Stage 2 is the word builder, fed by the stage-1 registers. It holds a P_OUT_W-bit shift accumulator, a bit count, a VN half-pair flag, a RAW channel index and a COUNT counter.
- RAW: every enabled cycle pushes the sample of channel idx, zero-extended. idx increments and wraps from P_CHANNELS-1 to 0. ad_or is ignored.
- XOR: bit = XOR of the LSBs of all channels.
  - If any ad_or bit is set, the sample is discarded and or_cnt increments.
  - Otherwise the accumulator becomes {acc[P_OUT_W-2:0], bit}, so the first bit ends in the MSB.
  - The P_OUT_W-th bit pushes the completed word and clears the bit count.
- VN: the XOR bit stream, with the same over-range discard, is taken in non-overlapping pairs. Pair 01 emits 0, pair 10 emits 1, pairs 00/11 emit nothing. Emitted bits accumulate exactly as in XOR mode.
- COUNT: every enabled cycle pushes the counter value, then increments it. The counter wraps at 2^P_OUT_W.
- Clearing partial state:
  - A change of registered mode, or a registered enable of 0, clears the accumulator, bit count, VN half-pair, idx and COUNT counter to 0.
  - FIFO contents are kept.
- FIFO: show-ahead.
  - A pop occurs when out_valid && out_ready.
  - A push while full drops the new word and increments ovf_cnt, unless a pop happens in the same cycle. In that case the push is accepted and ovf_cnt is unchanged.
- Statistics counters saturate at 0xFFFF. clr_stats zeroes them; an increment in the same cycle as clr_stats is lost.

## Timing
- Reset values: out_data 0, out_valid 0, or_cnt 0, ovf_cnt 0. All internal state and the FIFO are cleared. Reset has priority over every other event.
- Latency:
  - A sample presented at edge k is registered at k.
  - If it completes a word, the word is written at k+1.
  - out_valid is high after k+1 when the FIFO was empty, giving 2 cycles from input to out_valid.
- Throughput: one word per cycle in RAW/COUNT. XOR produces one word per P_OUT_W valid samples. VN produces at most one word per 2*P_OUT_W samples.
- out_data is stable while out_valid && !out_ready.
- Reset mid-word: the partial word is lost and the next word starts from bit 0.
- A mode change takes effect on the first sample registered with the new mode. The old partial word is discarded and never pushed.

## Structure
- Package adc_entropy_pkg holds:
  - mode encodings MODE_RAW, MODE_XOR, MODE_VN, MODE_COUNT;
  - STAT_W = 16;
  - the saturating-increment function.
- Sub-module rng_sync_fifo: parametrised width and depth, show-ahead, synchronous active-low reset, full/empty flags and a simultaneous push/pop rule.
- The word builder stays in the top module as one always block with a case on the registered mode.

## Test plan
- COUNT, enable=1, out_ready=1 from reset: out_valid rises 2 cycles after enable, and out_data runs 0, 1, 2, … with no gaps.
- XOR, P_CHANNELS=2, P_OUT_W=32: ch0 LSB toggles 1,0,…, ch1 LSB held 0, ad_or=0. After 32 samples exactly one word, 0xAAAAAAAA, appears 2 cycles after the 32nd sample.
- VN: XOR stream 0,1,1,0,0,0,1,1 repeated. After 128 samples exactly one word, 0x55555555, appears; 00/11 pairs produce nothing.
- Over-range: XOR mode with ad_or[1]=1 for 10 cycles inside an otherwise all-ones stream gives or_cnt=10. The word is 0xFFFFFFFF and completes 10 cycles later than without over-range.
- Backpressure: COUNT mode, depth 16, out_ready=0 for 20 enabled cycles gives ovf_cnt=4. Draining then returns 0..15 in order, after which out_valid=0.
- Reset and mode change: reset_n=0 for one cycle mid-XOR-word clears out_valid, both counters and the partial word. Switching XOR→RAW mid-word pushes no partial word, and the first RAW word is the ch0 sample.
